demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter DW, default 8, data width of every payload path.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  router can accept the word addressed by in_sel this cycle.
REQ-006 in_sel  input  2  destination channel 0..3 of the current word.
REQ-007 in_data  input  DW  payload.
REQ-008 out_valid  output  4  bit i: channel i holds a word.
REQ-009 out_ready  input  4  bit i: channel i consumer takes the word.
REQ-010 out_data  output  4*DW  channel i payload at bits [i*DW +: DW].
REQ-011 out_cnt  output  4*8  channel i delivered-word count at bits [i*8 +: 8].

Function
REQ-012 Each channel SHALL own one holding register (data + valid flag); channels SHALL be independent.
REQ-013 in_ready SHALL be combinational: !out_valid[in_sel] || out_ready[in_sel].
REQ-014 Input handshake (in_valid && in_ready) SHALL load in_data into slot in_sel and set out_valid[in_sel] at the next edge (latency 1 cycle).
REQ-015 Output handshake on channel i (out_valid[i] && out_ready[i]) SHALL clear out_valid[i] at the next edge unless REQ-016 applies.
REQ-016 Simultaneous input handshake to channel i and output handshake on channel i SHALL reload slot i with the new word and keep out_valid[i] = 1 (full throughput, no bubble).
REQ-017 While out_valid[i] = 1 and out_ready[i] = 0, out_valid[i] and out_data slice i SHALL hold stable.
REQ-018 Words accepted for different channels SHALL never overwrite one another; a word SHALL appear only on channel in_sel.
REQ-019 When in_valid = 0, no slot SHALL change except by output handshakes.
REQ-020 out_data slice i SHALL be don't-care while out_valid[i] = 0 but SHALL retain the last loaded value (no clearing on drain).
REQ-021 out_cnt slice i SHALL increment by 1 on each channel-i output handshake and wrap 255 -> 0 with no flag.
REQ-022 in_ready SHALL depend only on the addressed channel; a stalled channel SHALL NOT block words for other channels.
REQ-023 The block SHALL contain immediate assertions: on an input handshake, in_sel not X/Z; out_valid[i] never falls without out_ready[i]; out_data slice i stable while stalled; each failing with $error reporting channel and $time.

Reset
REQ-024 rst_n = 0 SHALL immediately force out_valid = 0, out_data = 0, out_cnt = 0, regardless of clk.
REQ-025 During reset in_ready SHALL read 1 (all slots empty) but no word SHALL be captured.
REQ-026 Reset asserted mid-transfer SHALL discard all held words; first edge after rst_n rises SHALL accept normally.
REQ-027 Assertions SHALL be disabled while rst_n = 0.

Verification
REQ-028 Reset, then in_sel=2, in_data=8'hA5, in_valid=1 one cycle, out_ready=4'b0100 -> out_valid=4'b0100 one cycle after capture, out_data[23:16]=8'hA5, out_cnt ch2 = 1, others 0.
REQ-029 out_ready=0, send 8'h11 to ch1 -> out_valid[1]=1 held; second word to ch1 sees in_ready=0 and is not taken; out_data ch1 stays 8'h11 for 10 cycles.
REQ-030 ch1 stalled with 8'h11, send 8'h22 to ch3 with out_ready[3]=1 -> in_ready=1, ch3 delivers 8'h22, ch1 still holds 8'h11.
REQ-031 ch0 out_ready=1 constant, in_valid=1, in_sel=0, data 0..9 back-to-back -> 10 consecutive deliveries 0..9 with no bubble, out_cnt ch0 = 10.
REQ-032 300 deliveries on ch3 -> out_cnt ch3 = 44 (wrap).
REQ-033 Words pending on ch0 and ch2, pulse rst_n low between edges -> out_valid=0, out_cnt=0 immediately; no assertion fires.

Source files
------------

// File: rtl/demux_router_if.sv
// demux_router_if -- handshake bundle between an upstream word source, the
// four-way demultiplexing router and its four channel consumers.
//   in_valid/in_ready/in_sel/in_data : upstream word and its destination channel
//   out_valid/out_ready              : per-channel handshake, bit i = channel i
//   out_data                         : channel i payload at [i*DW +: DW]
//   out_cnt                          : channel i delivered-word count at [i*8 +: 8]
// master = upstream source and consumers, slave = router.
interface demux_router_if #(
  parameter int DW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_sel;
  logic [DW-1:0]   in_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [4*DW-1:0] out_data;
  logic [31:0]     out_cnt;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );
endinterface

// File: rtl/demux_router.sv
// demux_router -- routes each upstream word to one of four channels selected
// by in_sel. Every channel owns a single holding register, so channels stall
// independently and a stalled channel never blocks words for the others.
// A slot that is drained and refilled in the same cycle stays valid, giving
// one word per cycle per channel. Each channel counts its deliveries (8-bit,
// wrapping).
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset; clears valid flags, data and counts
//   bus   : demux_router_if slave modport (see interface for signal list)
module demux_router #(
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_router_if.slave      bus
);

  logic [3:0]    vld_q, vld_d;
  logic [DW-1:0] data_q [4];
  logic [DW-1:0] data_d [4];
  logic [7:0]    cnt_q  [4];
  logic [7:0]    cnt_d  [4];
  logic          in_fire;
  logic [3:0]    out_fire;

  always_comb begin
    // Readiness looks only at the addressed slot: empty, or draining this cycle.
    bus.in_ready = !vld_q[bus.in_sel] || bus.out_ready[bus.in_sel];
    in_fire      = bus.in_valid && bus.in_ready;
    out_fire     = vld_q & bus.out_ready;
    vld_d        = vld_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i];
      if (out_fire[i]) begin
        vld_d[i] = 1'b0;
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
      // Load after the drain so a same-cycle refill keeps the slot valid.
      if (in_fire && (bus.in_sel == 2'(i))) begin
        vld_d[i]  = 1'b1;
        data_d[i] = bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    bus.out_valid = vld_q;
    bus.out_data  = '0;
    bus.out_cnt   = '0;
    for (int i = 0; i < 4; i++) begin
      bus.out_data[i*DW +: DW] = data_q[i];
      bus.out_cnt[i*8 +: 8]    = cnt_q[i];
    end
  end

  // Protocol checks; the next-state values stand in for "after this edge".
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && (bus.in_ready !== 1'b0)) begin
        assert (!$isunknown(bus.in_sel))
          else $error("demux_router: in_sel unknown on input handshake at %0t", $time);
      end
      for (int i = 0; i < 4; i++) begin
        if (vld_q[i] && !bus.out_ready[i]) begin
          assert (vld_d[i])
            else $error("demux_router: ch%0d out_valid dropped without out_ready at %0t", i, $time);
          assert (data_d[i] == data_q[i])
            else $error("demux_router: ch%0d out_data changed while stalled at %0t", i, $time);
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router -- directed scenarios plus randomized traffic for
// demux_router, checked every cycle against a transaction-level model: one
// queue of accepted words per channel, a delivery counter per channel and the
// last word loaded into each channel.
module tb_demux_router;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  demux_router_if #(.DW(8)) bus ();

  demux_router #(.DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef logic [7:0] word_q_t [$];
  word_q_t    sbq [4];
  logic [7:0] last_word [4];
  int         dlv_cnt [4];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       last_rdy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      sbq[i].delete();
      last_word[i] = 8'h00;
      dlv_cnt[i]   = 0;
    end
  endtask

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (sbq[i].size() > 0);
    return v;
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = last_word[i];
    return d;
  endfunction

  function automatic logic [31:0] exp_cnt();
    logic [31:0] c;
    for (int i = 0; i < 4; i++) c[i*8 +: 8] = 8'(dlv_cnt[i] % 256);
    return c;
  endfunction

  // One clock cycle: called at a falling edge, drives inputs, checks the
  // settled outputs, advances the model, and returns at the next falling edge.
  task automatic do_cycle(input logic v, input logic [1:0] sel, input logic [7:0] data,
                          input logic [3:0] ordy);
    logic       exp_rdy;
    logic [3:0] ev;
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = data;
    bus.out_ready = ordy;
    #1;
    ev      = exp_valid();
    exp_rdy = (sbq[sel].size() == 0) || ordy[sel];
    last_rdy = bus.in_ready;
    check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    check_eq("out_valid", {28'd0, bus.out_valid}, {28'd0, ev});
    check_eq("out_data", bus.out_data, exp_data());
    check_eq("out_cnt", bus.out_cnt, exp_cnt());
    for (int i = 0; i < 4; i++) begin
      if (ev[i] && ordy[i]) begin
        check_eq($sformatf("deliver_ch%0d", i), {24'd0, bus.out_data[i*8 +: 8]},
                 {24'd0, sbq[i][0]});
        void'(sbq[i].pop_front());
        dlv_cnt[i]++;
      end
    end
    if (v && exp_rdy) begin
      sbq[sel].push_back(data);
      last_word[sel] = data;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_valid"}, {28'd0, bus.out_valid}, 32'd0);
    check_eq({tag, "_data"}, bus.out_data, 32'd0);
    check_eq({tag, "_cnt"}, bus.out_cnt, 32'd0);
    check_eq({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Reset asserted between edges; a word offered during reset must be ignored.
  task automatic apply_reset(input string tag);
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd1;
    bus.in_data   = 8'h5A;
    bus.out_ready = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    reset_checks(tag);
    model_clear();
    @(posedge clk);
    #1;
    reset_checks({tag, "_hold"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 8'h00;
    bus.out_ready = 4'b0000;
    model_clear();
    @(negedge clk);
    apply_reset("rst0");

    // Single word to ch2, delivered one cycle after capture.
    do_cycle(1'b1, 2'd2, 8'hA5, 4'b0100);
    check_eq("a5_valid", {28'd0, bus.out_valid}, 32'h4);
    check_eq("a5_data", {24'd0, bus.out_data[23:16]}, 32'hA5);
    do_cycle(1'b0, 2'd0, 8'h00, 4'b0100);
    check_eq("a5_cnt", bus.out_cnt, 32'h0001_0000);

    // ch1 stalled: second word refused, first word held.
    do_cycle(1'b1, 2'd1, 8'h11, 4'b0000);
    do_cycle(1'b1, 2'd1, 8'h55, 4'b0000);
    check_eq("stall_rdy", {31'd0, last_rdy}, 32'd0);
    for (int k = 0; k < 10; k++) do_cycle(1'b0, 2'd1, 8'h00, 4'b0000);
    check_eq("stall_data", {24'd0, bus.out_data[15:8]}, 32'h11);

    // ch3 traffic flows past the stalled ch1.
    do_cycle(1'b1, 2'd3, 8'h22, 4'b1000);
    check_eq("bypass_rdy", {31'd0, last_rdy}, 32'd1);
    do_cycle(1'b0, 2'd0, 8'h00, 4'b1000);
    check_eq("bypass_ch1", {24'd0, bus.out_data[15:8]}, 32'h11);
    check_eq("bypass_cnt3", {24'd0, bus.out_cnt[31:24]}, 32'd1);
    do_cycle(1'b0, 2'd0, 8'h00, 4'b1111);

    // Back-to-back stream on ch0.
    for (int k = 0; k < 10; k++) do_cycle(1'b1, 2'd0, 8'(k), 4'b0001);
    do_cycle(1'b0, 2'd0, 8'h00, 4'b0001);
    check_eq("stream_cnt0", {24'd0, bus.out_cnt[7:0]}, 32'd10);

    // 300 deliveries on ch3 wrap the count to 44.
    @(negedge clk);
    apply_reset("rst1");
    for (int k = 0; k < 300; k++) do_cycle(1'b1, 2'd3, 8'($urandom), 4'b1000);
    do_cycle(1'b0, 2'd0, 8'h00, 4'b1000);
    check_eq("wrap_cnt3", {24'd0, bus.out_cnt[31:24]}, 32'd44);

    // Randomized traffic.
    for (int k = 0; k < 500; k++)
      do_cycle(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));

    // Words pending on ch0 and ch2, reset pulsed mid-cycle.
    do_cycle(1'b0, 2'd0, 8'h00, 4'b1111);
    do_cycle(1'b1, 2'd0, 8'h3C, 4'b0000);
    do_cycle(1'b1, 2'd2, 8'hC3, 4'b0000);
    check_eq("pend_valid", {28'd0, bus.out_valid}, 32'h5);
    apply_reset("rst2");
    do_cycle(1'b1, 2'd1, 8'h77, 4'b0010);
    check_eq("post_rst_valid", {28'd0, bus.out_valid}, 32'h2);
    do_cycle(1'b0, 2'd0, 8'h00, 4'b0010);
    check_eq("post_rst_cnt", bus.out_cnt, 32'h0000_0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
